// File: rtl/fft_frame_ctrl.sv
// Frame sequencer: paces ADC conversion requests, stores returned samples in the
// FFT sample buffer, then starts the FFT core and waits for it before the next frame.
module fft_frame_ctrl #(
    parameter int unsigned WIDTH      = 12,
    parameter int unsigned ADDR_W     = 3,
    parameter int unsigned SAMPLE_DIV = 16
) (
    input  logic              clk,
    input  logic              reset_async_n,
    input  logic              enable,
    input  logic              sample_valid,
    input  logic [WIDTH-1:0]  sample_data,
    output logic              adc_start,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [WIDTH-1:0]  buf_wdata,
    output logic              fft_start,
    input  logic              fft_done,
    output logic              busy,
    output logic              overrun,
    output logic [15:0]       frame_count
);

    localparam int unsigned DIV_W   = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned REQ_W   = ADDR_W + 1;
    localparam int unsigned FRAME_N = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, CAPTURE, START, COMPUTE} state_t;

    state_t            state, state_nxt;
    logic [DIV_W-1:0]  div_cnt, div_nxt;
    logic [REQ_W-1:0]  req_cnt, req_nxt;
    logic [ADDR_W-1:0] wr_ptr, wr_nxt;
    logic              pending, pend_nxt;
    logic              adc_start_nxt, buf_we_nxt, fft_start_nxt, busy_nxt, overrun_nxt;
    logic [ADDR_W-1:0] buf_addr_nxt;
    logic [WIDTH-1:0]  buf_wdata_nxt;
    logic [15:0]       frame_count_nxt;
    logic              launch_c;
    logic              write_c;

    always_ff @(posedge clk or negedge reset_async_n) begin
        if (!reset_async_n) begin
            state       <= IDLE;
            div_cnt     <= '0;
            req_cnt     <= '0;
            wr_ptr      <= '0;
            pending     <= 1'b0;
            adc_start   <= 1'b0;
            buf_we      <= 1'b0;
            buf_addr    <= '0;
            buf_wdata   <= '0;
            fft_start   <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            frame_count <= '0;
        end else begin
            state       <= state_nxt;
            div_cnt     <= div_nxt;
            req_cnt     <= req_nxt;
            wr_ptr      <= wr_nxt;
            pending     <= pend_nxt;
            adc_start   <= adc_start_nxt;
            buf_we      <= buf_we_nxt;
            buf_addr    <= buf_addr_nxt;
            buf_wdata   <= buf_wdata_nxt;
            fft_start   <= fft_start_nxt;
            busy        <= busy_nxt;
            overrun     <= overrun_nxt;
            frame_count <= frame_count_nxt;
        end
    end

    // Next state and registered outputs. Entering CAPTURE issues the first request
    // immediately, so the frame's first conversion goes out one cycle after the trigger.
    always_comb begin
        state_nxt       = state;
        div_nxt         = div_cnt;
        req_nxt         = req_cnt;
        wr_nxt          = wr_ptr;
        pend_nxt        = pending;
        adc_start_nxt   = 1'b0;
        buf_we_nxt      = 1'b0;
        buf_addr_nxt    = buf_addr;
        buf_wdata_nxt   = buf_wdata;
        fft_start_nxt   = 1'b0;
        overrun_nxt     = overrun;
        frame_count_nxt = frame_count;
        launch_c        = 1'b0;
        write_c         = 1'b0;

        case (state)
            IDLE: begin
                if (enable) launch_c = 1'b1;
            end
            CAPTURE: begin
                div_nxt = (div_cnt == DIV_W'(SAMPLE_DIV - 1)) ? '0 : div_cnt + DIV_W'(1);
                if (sample_valid && pending) begin
                    write_c       = 1'b1;
                    buf_we_nxt    = 1'b1;
                    buf_addr_nxt  = wr_ptr;
                    buf_wdata_nxt = sample_data;
                    wr_nxt        = wr_ptr + ADDR_W'(1);
                    pend_nxt      = 1'b0;
                end
                // Slot: a returning sample frees the slot before the request decision.
                if (div_cnt == '0 && enable && req_cnt < REQ_W'(FRAME_N)) begin
                    if (pend_nxt) begin
                        overrun_nxt = 1'b1;
                    end else begin
                        adc_start_nxt = 1'b1;
                        pend_nxt      = 1'b1;
                        req_nxt       = req_cnt + REQ_W'(1);
                    end
                end
                if (write_c && wr_ptr == ADDR_W'(FRAME_N - 1)) begin
                    state_nxt = START;
                end else if (!enable && !pend_nxt) begin
                    state_nxt = IDLE;
                end
            end
            START: begin
                fft_start_nxt = 1'b1;
                state_nxt     = COMPUTE;
            end
            COMPUTE: begin
                if (fft_done) begin
                    frame_count_nxt = frame_count + 16'd1;
                    if (enable) launch_c  = 1'b1;
                    else        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (launch_c) begin
            state_nxt     = CAPTURE;
            adc_start_nxt = 1'b1;
            pend_nxt      = 1'b1;
            req_nxt       = REQ_W'(1);
            div_nxt       = DIV_W'(1);
            wr_nxt        = '0;
        end

        if (state_nxt == IDLE) begin
            div_nxt = '0;
            req_nxt = '0;
            wr_nxt  = '0;
        end

        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl: ADC and FFT-core models driven on the falling
// edge, events logged with cycle stamps and compared against hand-derived values.
module tb_fft_frame_ctrl;

    localparam int unsigned WIDTH  = 12;
    localparam int unsigned ADDR_W = 3;

    logic              clk = 1'b0;
    logic              reset_async_n;
    logic              enable;
    logic              sample_valid = 1'b0;
    logic [WIDTH-1:0]  sample_data = '0;
    logic              fft_done = 1'b0;
    logic              adc_start;
    logic              buf_we;
    logic [ADDR_W-1:0] buf_addr;
    logic [WIDTH-1:0]  buf_wdata;
    logic              fft_start;
    logic              busy;
    logic              overrun;
    logic [15:0]       frame_count;

    fft_frame_ctrl #(
        .WIDTH(WIDTH),
        .ADDR_W(ADDR_W),
        .SAMPLE_DIV(16)
    ) dut (
        .clk(clk),
        .reset_async_n(reset_async_n),
        .enable(enable),
        .sample_valid(sample_valid),
        .sample_data(sample_data),
        .adc_start(adc_start),
        .buf_we(buf_we),
        .buf_addr(buf_addr),
        .buf_wdata(buf_wdata),
        .fft_start(fft_start),
        .fft_done(fft_done),
        .busy(busy),
        .overrun(overrun),
        .frame_count(frame_count)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int adc_t[$];
    int we_t[$];
    logic [ADDR_W-1:0] we_a[$];
    logic [WIDTH-1:0]  we_d[$];
    int fs_t[$];
    int fd_t[$];
    int adc_due[$];
    int fft_due = -1;
    int adc_lat = 5;
    int fft_lat = 30;
    logic [WIDTH-1:0] adc_val = 12'h100;
    int stray_sv_cyc = -1;
    int stray_fd_cyc = -1;

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ADC reader and FFT core models plus event logger.
    initial forever begin
        @(negedge clk);
        sample_valid = 1'b0;
        fft_done     = 1'b0;
        if (!reset_async_n) begin
            adc_due.delete();
            fft_due = -1;
        end else begin
            if (adc_start) begin
                adc_t.push_back(cyc);
                adc_due.push_back(cyc + adc_lat);
            end
            if (buf_we) begin
                we_t.push_back(cyc);
                we_a.push_back(buf_addr);
                we_d.push_back(buf_wdata);
            end
            if (fft_start) begin
                fs_t.push_back(cyc);
                fft_due = cyc + fft_lat;
            end
            if (adc_due.size() > 0 && adc_due[0] == cyc) begin
                void'(adc_due.pop_front());
                sample_valid = 1'b1;
                sample_data  = adc_val;
                adc_val      = adc_val + 12'd1;
            end else if (stray_sv_cyc == cyc) begin
                sample_valid = 1'b1;
                sample_data  = 12'hABC;
            end
            if (fft_due == cyc) begin
                fft_done = 1'b1;
                fd_t.push_back(cyc);
            end else if (stray_fd_cyc == cyc) begin
                fft_done = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_adc(input int n, input string tag);
        int k = 0;
        while (adc_t.size() < n && k < 3000) begin
            tick(1);
            k++;
        end
        chk(tag, 32'(adc_t.size() >= n), 1);
    endtask

    task automatic wait_we(input int n, input string tag);
        int k = 0;
        while (we_t.size() < n && k < 3000) begin
            tick(1);
            k++;
        end
        chk(tag, 32'(we_t.size() >= n), 1);
    endtask

    task automatic wait_fs(input int n, input string tag);
        int k = 0;
        while (fs_t.size() < n && k < 3000) begin
            tick(1);
            k++;
        end
        chk(tag, 32'(fs_t.size() >= n), 1);
    endtask

    task automatic wait_fc(input logic [15:0] n, input string tag);
        int k = 0;
        while (frame_count != n && k < 3000) begin
            tick(1);
            k++;
        end
        chk(tag, 32'(frame_count), 32'(n));
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 3000) begin
            tick(1);
            k++;
        end
        chk(tag, 32'(busy), 0);
    endtask

    initial begin
        int nw;
        reset_async_n = 1'b0;
        enable        = 1'b0;
        tick(3);
        chk("rst_strobes", 32'({adc_start, buf_we, fft_start}), 0);
        chk("rst_busy_ovr", 32'({busy, overrun}), 0);
        chk("rst_fc", 32'(frame_count), 0);
        #1 reset_async_n = 1'b1;
        tick(2);

        // Nominal frame, then the next frame starts on fft_done.
        enable = 1'b1;
        wait_adc(9, "nom_adc_to");
        for (int k = 1; k < 8; k++) chk("nom_gap", adc_t[k] - adc_t[k-1], 16);
        chk("nom_nwr", we_t.size(), 8);
        chk("nom_wr_lat", we_t[0] - adc_t[0], 6);
        for (int k = 0; k < 8; k++) begin
            chk("nom_addr", 32'(we_a[k]), k);
            chk("nom_data", 32'(we_d[k]), 32'h100 + k);
        end
        chk("nom_nfs", fs_t.size(), 1);
        chk("nom_fs_lat", fs_t[0] - we_t[7], 1);
        chk("nom_fc", 32'(frame_count), 1);
        chk("nom_restart", adc_t[8] - fd_t[0], 1);
        chk("nom_ovr", 32'(overrun), 0);

        // Disable after the 3rd write of frame 2 while the 4th conversion is pending.
        wait_adc(12, "dis_adc_to");
        enable = 1'b0;
        wait_idle("dis_idle_to");
        tick(40);
        chk("dis_nwr", we_t.size(), 12);
        chk("dis_addr", 32'(we_a[11]), 3);
        chk("dis_data", 32'(we_d[11]), 32'h10B);
        chk("dis_nadc", adc_t.size(), 12);
        chk("dis_busy", 32'(busy), 0);
        chk("dis_fc", 32'(frame_count), 1);
        chk("dis_nfs", fs_t.size(), 1);

        // Stray sample_valid and early fft_done, then a sample landing on a slot.
        enable = 1'b1;
        wait_adc(13, "stray_adc_to");
        stray_sv_cyc = cyc + 8;
        stray_fd_cyc = cyc + 10;
        tick(13);
        chk("stray_nwr", we_t.size(), 13);
        chk("stray_busy", 32'(busy), 1);
        chk("stray_fc", 32'(frame_count), 1);
        chk("stray_nfs", fs_t.size(), 1);
        adc_lat = 15;
        wait_adc(14, "coin_adc_to");
        adc_lat = 5;
        wait_adc(15, "coin_adc2_to");
        chk("coin_gap", adc_t[14] - adc_t[13], 16);
        chk("coin_ovr", 32'(overrun), 0);
        wait_adc(20, "f3_adc_to");
        adc_lat = 20;
        wait_fc(16'd2, "f3_fc");
        chk("f3_nwr", we_t.size(), 20);
        chk("f3_coin_data", 32'(we_d[13]), 32'h10D);
        chk("f3_last_addr", 32'(we_a[19]), 7);
        chk("f3_last_data", 32'(we_d[19]), 32'h113);

        // Overrun: ADC latency longer than the request spacing.
        wait_adc(21, "ovr_adc_to");
        tick(15);
        chk("ovr_flag", 32'(overrun), 1);
        chk("ovr_no_start", 32'(adc_start), 0);
        chk("ovr_nadc", adc_t.size(), 21);
        wait_adc(22, "ovr_adc2_to");
        chk("ovr_gap", adc_t[21] - adc_t[20], 32);
        wait_adc(28, "ovr_adc3_to");
        adc_lat = 5;
        wait_fc(16'd3, "ovr_fc");
        chk("ovr_nwr", we_t.size(), 28);
        chk("ovr_last_data", 32'(we_d[27]), 32'h11B);
        chk("ovr_sticky", 32'(overrun), 1);

        // Asynchronous reset in the middle of COMPUTE.
        wait_fs(4, "arst_fs_to");
        tick(5);
        #1 reset_async_n = 1'b0;
        #1;
        chk("arst_fc", 32'(frame_count), 0);
        chk("arst_busy_ovr", 32'({busy, overrun}), 0);
        chk("arst_buf", 32'({buf_we, buf_addr, buf_wdata}), 0);
        chk("arst_strobes", 32'({adc_start, fft_start}), 0);
        @(posedge clk);
        #3 reset_async_n = 1'b1;
        nw = we_t.size();
        wait_we(nw + 1, "arst_we_to");
        chk("arst_addr", 32'(we_a[nw]), 0);
        chk("arst_data", 32'(we_d[nw]), 32'h124);

        // frame_count wraps from 0xFFFF to 0.
        force dut.frame_count = 16'hFFFF;
        tick(1);
        release dut.frame_count;
        tick(1);
        chk("wrap_pre", 32'(frame_count), 32'hFFFF);
        wait_fc(16'h0000, "wrap_fc");
        chk("wrap_nfs", fs_t.size(), 5);
        enable = 1'b0;
        tick(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
